// File: rtl/mdr_read_unit.sv
// Read-side sequencer: memory request/ack handshake, data capture, then one-cycle bus drive.
// Optional MDR_TIMEOUT_EN adds a wait counter that aborts REQ/ARB after TIMEOUT cycles.
module mdr_read_unit #(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic [BITS-1:0] addr,
  output logic [BITS-1:0] mem_addr,
  output logic            mem_rd,
  input  logic            mem_ack,
  input  logic [BITS-1:0] mem_data,
  output logic            bus_req,
  input  logic            bus_grant,
  output logic [BITS-1:0] bus_out,
  output logic            bus_out_en,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ARB   = 3'd2,
    S_DRIVE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [BITS-1:0] mem_addr_q;
  logic [BITS-1:0] data_q;
  logic [BITS-1:0] bus_out_q;
  logic            mem_rd_q;
  logic            bus_req_q;
  logic            bus_out_en_q;
  logic            busy_q;
  logic            done_q;

`ifdef MDR_TIMEOUT_EN
  localparam int              CW        = $clog2(TIMEOUT + 1);
  // Count value seen on the edge that completes the TIMEOUT-th waiting cycle.
  localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0]              wait_q;
  logic                       error_q;
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      data_q       <= '0;
      bus_out_q    <= '0;
      mem_rd_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_out_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      wait_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mem_addr_q <= addr;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_REQ;
`ifdef MDR_TIMEOUT_EN
            wait_q     <= '0;
`endif
          end
        end
        S_REQ: begin
          // An ack wins over a grant seen on the same edge; the grant is re-sampled in ARB.
          if (mem_ack) begin
            data_q    <= mem_data;
            mem_rd_q  <= 1'b0;
            bus_req_q <= 1'b1;
            state_q   <= S_ARB;
`ifdef MDR_TIMEOUT_EN
            wait_q    <= '0;
`endif
          end
`ifdef MDR_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            error_q  <= 1'b1;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        S_ARB: begin
          if (bus_grant) begin
            bus_out_q    <= data_q;
            bus_out_en_q <= 1'b1;
            state_q      <= S_DRIVE;
          end
`ifdef MDR_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            error_q   <= 1'b1;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        S_DRIVE: begin
          bus_out_q    <= '0;
          bus_out_en_q <= 1'b0;
          bus_req_q    <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign bus_req     = bus_req_q;
  assign bus_out     = bus_out_q;
  assign bus_out_en  = bus_out_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;
`ifdef MDR_TIMEOUT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_read_unit.sv
// Bench for mdr_read_unit: timeline model per read (ack/grant delays) plus a bus-word scoreboard.
// Timeout scenarios are compiled in when MDR_TIMEOUT_EN is defined.
module tb_mdr_read_unit;
  localparam int BITS    = 32;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            clear;
  logic            start;
  logic [BITS-1:0] addr;
  logic [BITS-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_ack;
  logic [BITS-1:0] mem_data;
  logic            bus_req;
  logic            bus_grant;
  logic [BITS-1:0] bus_out;
  logic            bus_out_en;
  logic            busy;
  logic            done;
  logic            error;
  logic [2:0]      dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [BITS-1:0] exp_q[$];

  mdr_read_unit #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clear(clear), .start(start), .addr(addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_out(bus_out), .bus_out_en(bus_out_en),
    .busy(busy), .done(done), .error(error), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard: every driven bus word must be the next expected read ----------------
  always @(negedge clk) begin
    if (clear === 1'b1 && bus_out_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bus_word: bus_out=%h driven with no read outstanding", bus_out);
      end else begin
        logic [BITS-1:0] exp_w;
        exp_w = exp_q.pop_front();
        if (bus_out !== exp_w) begin
          miscompares++;
          $display("FAIL bus_word: bus_out=%h expected %h", bus_out, exp_w);
        end
      end
    end
  end

  // ---------------- driver: one read with ack da edges and grant dg edges after the previous phase ----------------
  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic do_read(input logic [BITS-1:0] a, input logic [BITS-1:0] d,
                         input int da, input int dg, input bit noise);
    int              last;
    logic [5:0]      exp_f;
    logic [5:0]      got_f;
    logic [BITS-1:0] exp_out;
    last = da + dg + 2;
    exp_q.push_back(d);
    start     = 1'b1;
    addr      = a;
    mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_grant = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_data  = noise ? $urandom : '0;
    @(posedge clk);
    for (int j = 0; j <= last; j++) begin
      int k;
      @(negedge clk);
      // j = cycles elapsed since the edge that accepted start
      exp_f   = {1'(j < da), 1'(j >= da && j <= da + dg), 1'(j == da + dg),
                 1'(j <= da + dg + 1), 1'(j == da + dg + 1), 1'b0};
      got_f   = {mem_rd, bus_req, bus_out_en, busy, done, error};
      exp_out = (j == da + dg) ? d : '0;
      vectors += 3;
      if (got_f !== exp_f) begin
        miscompares++;
        $display("FAIL read_flags j=%0d da=%0d dg=%0d: {rd,req,en,busy,done,err}=%b expected %b",
                 j, da, dg, got_f, exp_f);
      end
      if (bus_out !== exp_out) begin
        miscompares++;
        $display("FAIL read_bus_out j=%0d: bus_out=%h expected %h", j, bus_out, exp_out);
      end
      if (mem_addr !== a) begin
        miscompares++;
        $display("FAIL read_mem_addr j=%0d: mem_addr=%h expected %h", j, mem_addr, a);
      end
      if (j == last) break;
      k = j + 1;
      mem_ack   = (k == da) ? 1'b1 : ((noise && k > da) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus_grant = (k == da + dg) ? 1'b1 :
                  ((noise && (k <= da || k > da + dg)) ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_data  = (k == da) ? d : (noise ? $urandom : '0);
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      addr      = noise ? $urandom : a;
      @(posedge clk);
    end
    start     = 1'b0;
    mem_ack   = 1'b0;
    bus_grant = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear     = 1'b0;
    start     = 1'b1;
    mem_ack   = 1'b1;
    bus_grant = 1'b1;
    addr      = $urandom;
    mem_data  = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors += 2;
    if ({mem_rd, bus_req, bus_out_en, busy, done, error} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: {rd,req,en,busy,done,err}=%b expected 000000",
               {mem_rd, bus_req, bus_out_en, busy, done, error});
    end
    if ({mem_addr, bus_out} !== {2*BITS{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_words: mem_addr=%h bus_out=%h expected 0", mem_addr, bus_out);
    end
    clear     = 1'b1;
    start     = 1'b0;
    mem_ack   = 1'b0;
    bus_grant = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_rd, busy, mem_addr} !== {2'b00, {BITS{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_release_idle: mem_rd=%b busy=%b mem_addr=%h expected 0", mem_rd, busy, mem_addr);
    end
  endtask

  task automatic test_basic();
    do_read(32'h0000_0010, 32'hFFFF_FFFF, 1, 1, 1'b0);
  endtask

  task automatic test_delayed();
    do_read($urandom, 32'hA5A5_5A5A, 5, 3, 1'b1);
  endtask

  task automatic test_capture();
    // mem_data is zero on every edge except the ack edge
    do_read($urandom, $urandom, 2, 2, 1'b0);
    do_read($urandom, $urandom, 3, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_read($urandom, $urandom, $urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      do_read($urandom, $urandom, $urandom_range(1, 12), $urandom_range(1, 12), 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    start     = 1'b1;
    addr      = $urandom;
    mem_ack   = 1'b0;
    bus_grant = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    mem_ack  = 1'b1;
    mem_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    vectors++;
    if ({bus_req, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL midreset_in_arb: bus_req=%b busy=%b expected 1 1", bus_req, busy);
    end
    #2 clear = 1'b0;
    #1;
    vectors++;
    if ({mem_rd, bus_req, bus_out_en, busy, done, error} !== 6'b0) begin
      miscompares++;
      $display("FAIL midreset_async_drop: {rd,req,en,busy,done,err}=%b expected 000000",
               {mem_rd, bus_req, bus_out_en, busy, done, error});
    end
    bus_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus_out_en, done, error} !== 3'b000) begin
        miscompares++;
        $display("FAIL midreset_quiet: {en,done,err}=%b expected 000", {bus_out_en, done, error});
      end
    end
    clear     = 1'b1;
    bus_grant = 1'b0;
    @(negedge clk);
    do_read($urandom, $urandom, 2, 2, 1'b1);
  endtask

`ifdef MDR_TIMEOUT_EN
  task automatic test_timeout();
    logic [5:0] exp_f;
    // memory never acknowledges
    start = 1'b1;
    addr  = $urandom;
    @(posedge clk);
    start = 1'b0;
    for (int j = 0; j <= TIMEOUT + 1; j++) begin
      @(negedge clk);
      bus_grant = 1'($urandom_range(0, 1));
      exp_f = {1'(j < TIMEOUT), 1'b0, 1'b0, 1'(j < TIMEOUT), 1'b0, 1'(j == TIMEOUT)};
      vectors++;
      if ({mem_rd, bus_req, bus_out_en, busy, done, error} !== exp_f) begin
        miscompares++;
        $display("FAIL timeout_ack j=%0d: {rd,req,en,busy,done,err}=%b expected %b",
                 j, {mem_rd, bus_req, bus_out_en, busy, done, error}, exp_f);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus_grant = 1'b0;
    // ack after one edge, bus never granted
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    mem_ack = 1'b1;
    for (int j = 0; j <= TIMEOUT + 2; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) mem_ack = 1'b0;
      exp_f = {1'(j < 1), 1'(j >= 1 && j < 1 + TIMEOUT), 1'b0, 1'(j < 1 + TIMEOUT), 1'b0,
               1'(j == 1 + TIMEOUT)};
      vectors++;
      if ({mem_rd, bus_req, bus_out_en, busy, done, error} !== exp_f) begin
        miscompares++;
        $display("FAIL timeout_grant j=%0d: {rd,req,en,busy,done,err}=%b expected %b",
                 j, {mem_rd, bus_req, bus_out_en, busy, done, error}, exp_f);
      end
      if (j == TIMEOUT + 2) break;
      @(posedge clk);
    end
    // handshakes on the very edge the wait limit is reached still complete
    do_read($urandom, $urandom, TIMEOUT, TIMEOUT, 1'b1);
  endtask
`else
  task automatic test_long_wait();
    do_read($urandom, $urandom, 40, 25, 1'b1);
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_delayed();
    test_capture();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef MDR_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d reads never drove the bus, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdr_read_unit.md
# mdr_read_unit

Read-side sequencer for the memory data path: accepts a read command with an address and runs a request/acknowledge handshake with memory. It captures the returned word into an internal data register, then arbitrates for the shared bus and drives the word onto it for exactly one cycle. It is the source end of the bus transfer that the bus-loaded registers consume. It sits between the memory interface and the datapath bus, alongside the MAR/MDR pair.

## Interface
Parameters:
- BITS, 32, data and address width
- TIMEOUT, 15, max cycles waiting for mem_ack or bus_grant before error (only with MDR_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, all state updates on posedge
- clear  input  1  asynchronous, active-low reset
- start  input  1  read command strobe, sampled only in IDLE
- addr  input  BITS  read address, captured on accepted start
- mem_addr  output  BITS  address presented to memory
- mem_rd  output  1  memory read request
- mem_ack  input  1  memory data valid
- mem_data  input  BITS  memory read data
- bus_req  output  1  request for bus ownership
- bus_grant  input  1  bus ownership granted
- bus_out  output  BITS  word driven to bus, zero when not driving
- bus_out_en  output  1  bus drive enable
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle completion pulse
- error  output  1  one-cycle timeout pulse

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on clear. Any state is forced to IDLE immediately on clear low.
- Reset values: mem_addr=0, mem_rd=0, bus_req=0, bus_out=0, bus_out_en=0, busy=0, done=0, error=0. The data register and wait counter are also 0.
- IDLE: start=1 latches addr into mem_addr and moves to REQ. start=0 stays in IDLE.
- REQ: mem_rd=1.
  - mem_ack=1 latches mem_data into the data register, drops mem_rd and moves to ARB.
- ARB: bus_req=1.
  - bus_grant=1 moves to DRIVE.
- DRIVE: bus_out_en=1 and bus_out=data register for exactly one cycle. bus_req stays high. Moves to DONE.
- DONE: done=1 for one cycle. bus_out returns to 0. Moves to IDLE.
- start is ignored outside IDLE; there is no queuing.
- mem_ack outside REQ and bus_grant outside ARB are ignored.
- mem_ack and bus_grant high in the same REQ cycle: only the ack is taken. The grant is re-sampled in ARB on the following cycle.
- Reset mid-transaction: the transaction is abandoned with no done and no error. mem_rd, bus_req and bus_out_en drop asynchronously.

## Timing
- start accepted at edge N: mem_rd=1 from N+1.
- mem_ack sampled high at edge M: data captured at M and bus_req=1 from M+1.
- bus_grant sampled high at edge G:
  - bus_out_en=1 for the cycle G..G+1.
  - done=1 for the cycle G+1..G+2.
  - busy=0 from G+2.
- Minimum latency, with ack and grant already high: start to bus_out_en is 3 cycles, start to done is 4 cycles.
- Back-to-back: start may be accepted on the edge where the state is IDLE, i.e. the cycle after done.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- MDR_TIMEOUT_EN defined:
  - A wait counter clears on entry to REQ and ARB and increments each cycle spent there.
  - If the counter reaches TIMEOUT without ack/grant, error=1 for one cycle. mem_rd, bus_req and busy drop and the state returns to IDLE. No bus drive and no done.
  - Ack or grant on the same edge the counter hits TIMEOUT wins; no error.
- MDR_TIMEOUT_EN undefined: no counter. The unit waits indefinitely in REQ/ARB and error is tied to 0.

## Test plan
- Reset: hold clear=0 with start=1 and mem_ack=1 -> all outputs 0 and busy=0. Release clear -> first start is accepted normally.
- Basic read: addr=32'h0000_0010, mem_ack and bus_grant tied high, mem_data=32'hFFFF_FFFF.
  - Required: mem_addr=32'h10 one cycle after start.
  - Required: bus_out=32'hFFFF_FFFF with bus_out_en for exactly one cycle, 3 cycles after start.
  - Required: done 4 cycles after start, then bus_out=0.
- Delayed handshakes: mem_ack raised 5 cycles after mem_rd, bus_grant 3 cycles after bus_req, mem_data=32'hA5A5_5A5A.
  - Required: mem_rd high exactly 5 cycles.
  - Required: bus_out=32'hA5A5_5A5A; start pulses during busy are ignored.
- Data capture isolation: mem_data changes to 32'h0 the cycle after ack -> bus_out still shows the value captured at ack.
- Mid-transaction reset: assert clear=0 while in ARB -> bus_req drops immediately, no done and no error. A following read completes.
- Timeout (MDR_TIMEOUT_EN, TIMEOUT=15): mem_ack held low -> error pulse once mem_rd has been high 15 cycles, then busy=0 and no bus_out_en. Repeat with ack on the 15th edge -> no error and normal completion.
